// File: rtl/feature_window_avg_if.sv
// Sample-stream and feature-result bundle for the windowed feature extractor.
interface feature_window_avg_if #(
   parameter int unsigned NUM_CH   = 3,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned WIN_LOG2 = 3
);
   logic                       sample_valid;
   logic [NUM_CH*DATA_W-1:0]   sample_in;
   logic                       clear;
   logic [NUM_CH*DATA_W-1:0]   avg_out;
   logic [NUM_CH*DATA_W-1:0]   peak_out;
   logic                       feat_valid;
   logic [WIN_LOG2-1:0]        fill_cnt;
   logic [15:0]                win_cnt;

   // Sensor front-end side: drives samples, observes features.
   modport master (
      output sample_valid, sample_in, clear,
      input  avg_out, peak_out, feat_valid, fill_cnt, win_cnt
   );

   // Extractor side.
   modport slave (
      input  sample_valid, sample_in, clear,
      output avg_out, peak_out, feat_valid, fill_cnt, win_cnt
   );
endinterface

// File: rtl/feature_window_avg.sv
// Per-channel windowed mean/peak extractor. Every channel accumulates the same
// WIN = 2**WIN_LOG2 accepted samples; on the closing sample the mean and peak are
// published together with a one-cycle feat_valid strobe.
module feature_window_avg #(
   parameter int unsigned NUM_CH   = 3,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned WIN_LOG2 = 3
) (
   input logic                 clk,
   input logic                 rst,
   feature_window_avg_if.slave bus
);
   localparam int unsigned ACC_W = DATA_W + WIN_LOG2;
   // fill_cnt value while the window's final sample is being accepted (WIN-1).
   localparam logic [WIN_LOG2-1:0] LAST_FILL = '1;

   logic [DATA_W-1:0]   smp      [NUM_CH];
   logic [ACC_W-1:0]    sum_acc  [NUM_CH];
   logic [DATA_W-1:0]   peak_acc [NUM_CH];

   logic [ACC_W-1:0]    sum_q    [NUM_CH];
   logic [ACC_W-1:0]    sum_d    [NUM_CH];
   logic [DATA_W-1:0]   peak_q   [NUM_CH];
   logic [DATA_W-1:0]   peak_d   [NUM_CH];
   logic [DATA_W-1:0]   avg_q    [NUM_CH];
   logic [DATA_W-1:0]   avg_d    [NUM_CH];
   logic [DATA_W-1:0]   pk_out_q [NUM_CH];
   logic [DATA_W-1:0]   pk_out_d [NUM_CH];
   logic [WIN_LOG2-1:0] fill_q, fill_d;
   logic [15:0]         win_q, win_d;
   logic                feat_q, feat_d;
   logic                accept, close;

   // Unpack channels and publish registered results onto the bus.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign smp[g] = bus.sample_in[g*DATA_W +: DATA_W];
      assign bus.avg_out[g*DATA_W +: DATA_W]  = avg_q[g];
      assign bus.peak_out[g*DATA_W +: DATA_W] = pk_out_q[g];
   end

   assign bus.feat_valid = feat_q;
   assign bus.fill_cnt   = fill_q;
   assign bus.win_cnt    = win_q;

   // Candidate running sum/peak if this cycle's sample were accepted.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         sum_acc[k]  = sum_q[k] + ACC_W'(smp[k]);
         peak_acc[k] = (smp[k] > peak_q[k]) ? smp[k] : peak_q[k];
      end
   end

   // Clear wins over a valid sample; the window closes on its WIN-th accepted sample.
   always_comb begin
      accept = bus.sample_valid && !bus.clear;
      close  = accept && (fill_q == LAST_FILL);
   end

   // Next-state for accumulators, counters and published features.
   always_comb begin
      sum_d    = sum_q;
      peak_d   = peak_q;
      avg_d    = avg_q;
      pk_out_d = pk_out_q;
      fill_d   = fill_q;
      win_d    = win_q;
      feat_d   = 1'b0;
      if (bus.clear) begin
         for (int k = 0; k < NUM_CH; k++) begin
            sum_d[k]  = '0;
            peak_d[k] = '0;
         end
         fill_d = '0;
      end else if (close) begin
         for (int k = 0; k < NUM_CH; k++) begin
            // Truncating divide by WIN: drop the low WIN_LOG2 bits.
            avg_d[k]    = sum_acc[k][WIN_LOG2 +: DATA_W];
            pk_out_d[k] = peak_acc[k];
            sum_d[k]    = '0;
            peak_d[k]   = '0;
         end
         fill_d = '0;
         win_d  = win_q + 16'd1;
         feat_d = 1'b1;
      end else if (accept) begin
         for (int k = 0; k < NUM_CH; k++) begin
            sum_d[k]  = sum_acc[k];
            peak_d[k] = peak_acc[k];
         end
         fill_d = fill_q + WIN_LOG2'(1);
      end
   end

   // State registers; async reset clears everything including published outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            sum_q[k]    <= '0;
            peak_q[k]   <= '0;
            avg_q[k]    <= '0;
            pk_out_q[k] <= '0;
         end
         fill_q <= '0;
         win_q  <= '0;
         feat_q <= 1'b0;
      end else begin
         sum_q    <= sum_d;
         peak_q   <= peak_d;
         avg_q    <= avg_d;
         pk_out_q <= pk_out_d;
         fill_q   <= fill_d;
         win_q    <= win_d;
         feat_q   <= feat_d;
      end
   end
endmodule

// File: tb/tb_feature_window_avg.sv
// Directed bench for feature_window_avg: main 3-channel/WIN=8 instance plus a
// 1-channel/WIN=2 instance sharing the clock and reset.
module tb_feature_window_avg;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   pulses;
   int   p0;

   feature_window_avg_if #(.NUM_CH(3), .DATA_W(16), .WIN_LOG2(3)) bus0 ();
   feature_window_avg_if #(.NUM_CH(1), .DATA_W(16), .WIN_LOG2(1)) bus1 ();

   feature_window_avg #(.NUM_CH(3), .DATA_W(16), .WIN_LOG2(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   feature_window_avg #(.NUM_CH(1), .DATA_W(16), .WIN_LOG2(1)) dut_small (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count feat_valid pulses, sampled mid-cycle.
   always @(negedge clk) if (bus0.feat_valid === 1'b1) pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ch(input logic [47:0] v, input int k);
      return v[k*16 +: 16];
   endfunction

   // One clock with the given inputs; inputs return to idle just after the edge.
   task automatic drv(input logic v, input logic c, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] d);
      bus0.sample_valid = v;
      bus0.clear        = c;
      bus0.sample_in    = {d, b, a};
      @(posedge clk);
      #1;
      bus0.sample_valid = 1'b0;
      bus0.clear        = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      pulses  = 0;
      rst     = 1'b0;
      bus0.sample_valid = 1'b0;
      bus0.clear        = 1'b0;
      bus0.sample_in    = '0;
      bus1.sample_valid = 1'b0;
      bus1.clear        = 1'b0;
      bus1.sample_in    = '0;

      // 1: reset with no clock edge yet
      #1 rst = 1'b1;
      #1;
      chk("rst_avg",  bus0.avg_out[31:0], 32'h0);
      chk("rst_peak", bus0.peak_out[31:0], 32'h0);
      chk("rst_fv",   32'(bus0.feat_valid), 32'h0);
      chk("rst_fill", 32'(bus0.fill_cnt), 32'h0);
      chk("rst_win",  32'(bus0.win_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      pulses = 0;

      // WIN=2 single-channel instance: 3,4 -> avg 3, peak 4
      bus1.sample_valid = 1'b1;
      bus1.sample_in    = 16'd3;
      @(posedge clk);
      #1;
      chk("small_fv0", 32'(bus1.feat_valid), 32'h0);
      bus1.sample_in = 16'd4;
      @(posedge clk);
      #1;
      bus1.sample_valid = 1'b0;
      chk("small_fv",   32'(bus1.feat_valid), 32'h1);
      chk("small_avg",  32'(bus1.avg_out), 32'd3);
      chk("small_peak", 32'(bus1.peak_out), 32'd4);

      // 2: 8 consecutive samples
      for (int i = 0; i < 7; i++) drv(1'b1, 1'b0, 16'(10 + i), 16'd100, 16'd0);
      chk("t2_fv_early", 32'(bus0.feat_valid), 32'h0);
      chk("t2_fill7",    32'(bus0.fill_cnt), 32'd7);
      drv(1'b1, 1'b0, 16'd17, 16'd100, 16'd0);
      chk("t2_fv",    32'(bus0.feat_valid), 32'h1);
      chk("t2_avg0",  32'(ch(bus0.avg_out, 0)), 32'd13);
      chk("t2_peak0", 32'(ch(bus0.peak_out, 0)), 32'd17);
      chk("t2_avg1",  32'(ch(bus0.avg_out, 1)), 32'd100);
      chk("t2_peak1", 32'(ch(bus0.peak_out, 1)), 32'd100);
      chk("t2_avg2",  32'(ch(bus0.avg_out, 2)), 32'd0);
      chk("t2_win",   32'(bus0.win_cnt), 32'd1);
      chk("t2_fill0", 32'(bus0.fill_cnt), 32'd0);
      idle(1);
      chk("t2_fv_drop", 32'(bus0.feat_valid), 32'h0);
      chk("t2_hold",    32'(ch(bus0.avg_out, 0)), 32'd13);

      // 3: same data with gaps
      p0 = pulses;
      for (int i = 0; i < 7; i++) begin
         drv(1'b1, 1'b0, 16'(10 + i), 16'd100, 16'd0);
         idle((i % 3) + 1);
      end
      chk("t3_no_pulse", 32'(pulses), 32'(p0));
      chk("t3_fill7",    32'(bus0.fill_cnt), 32'd7);
      drv(1'b1, 1'b0, 16'd17, 16'd100, 16'd0);
      chk("t3_fv",    32'(bus0.feat_valid), 32'h1);
      chk("t3_avg0",  32'(ch(bus0.avg_out, 0)), 32'd13);
      chk("t3_peak0", 32'(ch(bus0.peak_out, 0)), 32'd17);
      chk("t3_avg1",  32'(ch(bus0.avg_out, 1)), 32'd100);
      chk("t3_win",   32'(bus0.win_cnt), 32'd2);
      idle(1);

      // 4: full-scale and truncation
      for (int i = 0; i < 8; i++) drv(1'b1, 1'b0, 16'hFFFF, (i == 7) ? 16'd7 : 16'd0, 16'd0);
      chk("t4_fv",    32'(bus0.feat_valid), 32'h1);
      chk("t4_avg0",  32'(ch(bus0.avg_out, 0)), 32'hFFFF);
      chk("t4_peak0", 32'(ch(bus0.peak_out, 0)), 32'hFFFF);
      chk("t4_avg1",  32'(ch(bus0.avg_out, 1)), 32'd0);
      chk("t4_peak1", 32'(ch(bus0.peak_out, 1)), 32'd7);
      chk("t4_win",   32'(bus0.win_cnt), 32'd3);
      idle(1);

      // 5: clear drops partial window and the sample presented with it
      for (int i = 0; i < 5; i++) drv(1'b1, 1'b0, 16'd50, 16'd50, 16'd50);
      chk("t5_fill5", 32'(bus0.fill_cnt), 32'd5);
      p0 = pulses;
      drv(1'b1, 1'b1, 16'd99, 16'd99, 16'd99);
      chk("t5_clr_fill", 32'(bus0.fill_cnt), 32'd0);
      chk("t5_clr_fv",   32'(bus0.feat_valid), 32'h0);
      chk("t5_clr_avg",  32'(ch(bus0.avg_out, 0)), 32'hFFFF);
      chk("t5_clr_win",  32'(bus0.win_cnt), 32'd3);
      for (int i = 0; i < 7; i++) drv(1'b1, 1'b0, 16'd4, 16'd4, 16'd4);
      chk("t5_no_pulse", 32'(pulses), 32'(p0));
      drv(1'b1, 1'b0, 16'd4, 16'd4, 16'd4);
      chk("t5_fv",    32'(bus0.feat_valid), 32'h1);
      chk("t5_avg0",  32'(ch(bus0.avg_out, 0)), 32'd4);
      chk("t5_peak0", 32'(ch(bus0.peak_out, 0)), 32'd4);
      chk("t5_peak2", 32'(ch(bus0.peak_out, 2)), 32'd4);
      chk("t5_win",   32'(bus0.win_cnt), 32'd4);
      idle(1);

      // 6: 16 back-to-back samples 0..15, then async reset mid-window
      p0 = pulses;
      for (int i = 0; i < 8; i++) drv(1'b1, 1'b0, 16'(i), 16'd1, 16'd2);
      chk("t6_fv_a",   32'(bus0.feat_valid), 32'h1);
      chk("t6_avg_a",  32'(ch(bus0.avg_out, 0)), 32'd3);
      chk("t6_peak_a", 32'(ch(bus0.peak_out, 0)), 32'd7);
      for (int i = 8; i < 16; i++) drv(1'b1, 1'b0, 16'(i), 16'd1, 16'd2);
      chk("t6_fv_b",   32'(bus0.feat_valid), 32'h1);
      chk("t6_avg_b",  32'(ch(bus0.avg_out, 0)), 32'd11);
      chk("t6_peak_b", 32'(ch(bus0.peak_out, 0)), 32'd15);
      chk("t6_win",    32'(bus0.win_cnt), 32'd6);
      for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, 16'd30, 16'd30, 16'd30);
      chk("t6_pulses", 32'(pulses), 32'(p0 + 2));
      chk("t6_fill3",  32'(bus0.fill_cnt), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_fill", 32'(bus0.fill_cnt), 32'd0);
      chk("t6_rst_avg",  32'(ch(bus0.avg_out, 0)), 32'd0);
      chk("t6_rst_peak", 32'(ch(bus0.peak_out, 0)), 32'd0);
      chk("t6_rst_win",  32'(bus0.win_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 7; i++) drv(1'b1, 1'b0, 16'd20, 16'd21, 16'd22);
      chk("t6_post_fv0",  32'(bus0.feat_valid), 32'h0);
      chk("t6_post_fill", 32'(bus0.fill_cnt), 32'd7);
      drv(1'b1, 1'b0, 16'd20, 16'd21, 16'd22);
      chk("t6_post_fv",   32'(bus0.feat_valid), 32'h1);
      chk("t6_post_avg0", 32'(ch(bus0.avg_out, 0)), 32'd20);
      chk("t6_post_pk2",  32'(ch(bus0.peak_out, 2)), 32'd22);
      chk("t6_post_win",  32'(bus0.win_cnt), 32'd1);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
